// File: rtl/sfq_arb_pkg.sv
// Shared constants and helpers for the SFQ merger round-robin arbiter.
package sfq_arb_pkg;

    // Default build of the arbiter: four requesters, 3-bit burst counters,
    // two idle cycles of merger recovery between output pulses.
    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 3;
    localparam int GAP_DEF   = 2;

    // Index width for a range of n values; never collapses to zero bits so
    // that single-entry ranges still yield a legal vector.
    function automatic int IDX_W(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sfq_rr_picker.sv
// Combinational round-robin picker: returns the first requesting index found
// when scanning from ptr upwards, wrapping modulo N_REQ.
module sfq_rr_picker
    import sfq_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW   = IDX_W(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    // rot_idx[k] is the requester visited k steps after ptr; rot_req[k] is
    // its request bit. Scanning rot_req from 0 gives round-robin priority.
    logic [IW-1:0]    rot_idx [N_REQ];
    logic [N_REQ-1:0] rot_req;

    localparam logic [IW:0] N_WIDE = (IW+1)'(N_REQ);

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IW:0] sum;
            logic [IW:0] wrapped;

            // ptr is always below N_REQ, so one conditional subtract wraps it.
            assign sum        = {1'b0, ptr} + (IW+1)'(gi);
            assign wrapped    = (sum >= N_WIDE) ? (sum - N_WIDE) : sum;
            assign rot_idx[gi] = wrapped[IW-1:0];
            assign rot_req[gi] = req[wrapped[IW-1:0]];
        end
    endgenerate

    assign valid = |req;

    // Lowest rotated position wins: iterate downwards so the last hit is the
    // one closest to ptr.
    always_comb begin
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                winner = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/sfq_merge_arbiter.sv
// Round-robin scheduler sharing one SFQ merger output between N_REQ pulse
// requesters. Bursts are absorbed by per-requester pending counters and the
// output honours a minimum idle gap for merger recovery.
module sfq_merge_arbiter
    import sfq_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP   = GAP_DEF,
    localparam int IW   = IDX_W(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             ovf_clr,
    output logic             out_pulse,
    output logic [IW-1:0]    out_src,
    output logic             pending_any,
    output logic [N_REQ-1:0] overflow
);

    // gap_cnt must be able to hold the value GAP itself.
    localparam int GW = IDX_W(GAP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP);
    localparam logic [IW-1:0]    LAST_IDX = IW'(N_REQ - 1);

    // Architectural state
    logic [N_REQ-1:0][CNT_W-1:0] cnt_reg;
    logic [N_REQ-1:0][CNT_W-1:0] cnt_next;
    logic [IW-1:0]               rr_ptr_reg;
    logic [IW-1:0]               rr_ptr_next;
    logic [GW-1:0]               gap_cnt_reg;
    logic [GW-1:0]               gap_cnt_next;
    logic                        out_pulse_reg;
    logic [IW-1:0]               out_src_reg;
    logic [IW-1:0]               out_src_next;
    logic                        pending_any_reg;
    logic [N_REQ-1:0]            overflow_reg;
    logic [N_REQ-1:0]            overflow_next;

    // Arbitration signals
    logic [N_REQ-1:0] cnt_nz;
    logic [N_REQ-1:0] granted;
    logic [N_REQ-1:0] ovf_set;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic             grant;

    sfq_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (cnt_nz),
        .ptr    (rr_ptr_reg),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // A grant needs the arbiter enabled, the merger recovered and work queued.
    assign grant = enable && (gap_cnt_reg == '0) && pick_valid;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            logic at_max;
            logic inc;
            logic dec;

            assign cnt_nz[gi]  = (cnt_reg[gi] != '0);
            assign granted[gi] = grant && (pick_idx == IW'(gi));
            assign at_max      = (cnt_reg[gi] == CNT_MAX);

            // A request arriving on the same edge as its own grant cancels
            // out: the count holds and nothing is lost, even when full.
            assign inc         = req_pulse[gi] && !granted[gi] && !at_max;
            assign dec         = granted[gi] && !req_pulse[gi];
            assign ovf_set[gi] = req_pulse[gi] && !granted[gi] && at_max;

            assign cnt_next[gi] = inc ? (cnt_reg[gi] + CNT_W'(1)) :
                                  dec ? (cnt_reg[gi] - CNT_W'(1)) :
                                        cnt_reg[gi];
        end
    endgenerate

    // Pointer, gap timer and source index advance only on a grant; the gap
    // timer otherwise drains towards zero regardless of enable.
    always_comb begin
        rr_ptr_next  = rr_ptr_reg;
        out_src_next = out_src_reg;
        gap_cnt_next = gap_cnt_reg;
        if (grant) begin
            rr_ptr_next  = (pick_idx == LAST_IDX) ? '0 : (pick_idx + IW'(1));
            out_src_next = pick_idx;
            gap_cnt_next = GAP_LOAD;
        end else if (gap_cnt_reg != '0) begin
            gap_cnt_next = gap_cnt_reg - GW'(1);
        end
    end

    // Sticky loss flags: a new loss on the clearing edge survives the clear.
    always_comb begin
        overflow_next = (overflow_reg & ~{N_REQ{ovf_clr}}) | ovf_set;
    end

    // State and registered outputs, discarded by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg         <= '0;
            rr_ptr_reg      <= '0;
            gap_cnt_reg     <= '0;
            out_pulse_reg   <= 1'b0;
            out_src_reg     <= '0;
            pending_any_reg <= 1'b0;
            overflow_reg    <= '0;
        end else begin
            cnt_reg         <= cnt_next;
            rr_ptr_reg      <= rr_ptr_next;
            gap_cnt_reg     <= gap_cnt_next;
            out_pulse_reg   <= grant;
            out_src_reg     <= out_src_next;
            pending_any_reg <= |cnt_next;
            overflow_reg    <= overflow_next;
        end
    end

    assign out_pulse   = out_pulse_reg;
    assign out_src     = out_src_reg;
    assign pending_any = pending_any_reg;
    assign overflow    = overflow_reg;

endmodule
